// File: rtl/spim_wb.sv
// rtl/spim_wb.sv - Wishbone-slave SPI master with legacy bit-bang register
module spim_wb #(
  parameter int          DW      = 8,
  parameter int          NCS     = 4,
  parameter logic [15:0] DIV_RST = 16'd3
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [31:0]    wb_adr_i,
  input  logic [31:0]    wb_dat_i,
  output logic [31:0]    wb_dat_o,
  input  logic           wb_we_i,
  input  logic [3:0]     wb_sel_i,
  input  logic           wb_stb_i,
  input  logic           wb_cyc_i,
  output logic           wb_ack_o,
  output logic [NCS-1:0] spi_ss,
  output logic           spi_sck,
  output logic           spi_mosi,
  input  logic           spi_miso
);

  localparam int EW = $clog2(2*DW+1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  state_t state, state_nxt;

  logic [3:0]     ctrl;
  logic [15:0]    div;
  logic [NCS-1:0] cs;
  logic [3:1]     bb;
  logic           done, ovr, busy;
  logic [DW-1:0]  rx, tx_sh, rx_sh, rx_nxt;
  logic           cpha_s, cpol_s, lsb_s;
  logic [15:0]    div_s, half;
  logic [EW-1:0]  edges;
  logic           sck_q, mosi_q;

  logic           acc, wr, rd, data_wr;
  logic [2:0]     reg_sel;
  logic [31:0]    rdata;
  logic           start, edge_tick, last_edge, lead, sample, drive;
  logic           unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  assign acc     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = acc & wb_we_i;
  assign rd      = acc & ~wb_we_i;
  assign reg_sel = wb_adr_i[4:2];
  assign data_wr = wr && (reg_sel == 3'd3);
  assign busy    = (state == S_SHIFT);

  // Edge counter starts even, so even counts are leading edges.
  assign lead    = ~edges[0];
  assign sample  = edge_tick & (lead ^ cpha_s);
  assign drive   = edge_tick & ~(lead ^ cpha_s);
  assign rx_nxt  = lsb_s ? {spi_miso, rx_sh[DW-1:1]} : {rx_sh[DW-2:0], spi_miso};

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    edge_tick = 1'b0;
    last_edge = 1'b0;
    case (state)
      S_IDLE: begin
        if (data_wr && !ctrl[3]) begin
          start     = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (half == 16'd0) begin
          edge_tick = 1'b1;
          if (edges == EW'(1)) begin
            last_edge = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      3'd0: rdata = {28'd0, ctrl};
      3'd1: rdata = {16'd0, div};
      3'd2: rdata = 32'(cs);
      3'd3: rdata = 32'(rx);
      3'd4: rdata = {29'd0, ovr, done, busy};
      3'd5: rdata = {28'd0, bb, spi_miso};
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      ctrl     <= 4'd0;
      div      <= DIV_RST;
      cs       <= '1;
      bb       <= 3'd0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      rx       <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpha_s   <= 1'b0;
      cpol_s   <= 1'b0;
      lsb_s    <= 1'b0;
      div_s    <= 16'd0;
      half     <= 16'd0;
      edges    <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wb_ack_o <= acc;
      wb_dat_o <= rd ? rdata : 32'd0;

      if (wr) begin
        case (reg_sel)
          3'd0: ctrl <= wb_dat_i[3:0];
          3'd1: div  <= wb_dat_i[15:0];
          3'd2: cs   <= wb_dat_i[NCS-1:0];
          3'd3: if (ctrl[3] || busy) ovr <= 1'b1;
          3'd4: if (wb_dat_i[2]) ovr <= 1'b0;
          3'd5: bb   <= wb_dat_i[3:1];
          default: ;
        endcase
      end

      if (rd && reg_sel == 3'd3) done <= 1'b0;

      if (start) begin
        cpha_s <= ctrl[0];
        cpol_s <= ctrl[1];
        lsb_s  <= ctrl[2];
        div_s  <= div;
        half   <= div;
        edges  <= EW'(2*DW);
        sck_q  <= ctrl[1];
        rx_sh  <= '0;
        done   <= 1'b0;
        // CPHA=0 presents the first bit before the first clock edge.
        if (!ctrl[0]) begin
          mosi_q <= ctrl[2] ? wb_dat_i[0] : wb_dat_i[DW-1];
          tx_sh  <= ctrl[2] ? (wb_dat_i[DW-1:0] >> 1) : (wb_dat_i[DW-1:0] << 1);
        end else begin
          tx_sh  <= wb_dat_i[DW-1:0];
        end
      end

      if (busy) begin
        if (edge_tick) begin
          sck_q <= ~sck_q;
          half  <= div_s;
          edges <= edges - EW'(1);
          if (sample) rx_sh <= rx_nxt;
          if (drive) begin
            mosi_q <= lsb_s ? tx_sh[0] : tx_sh[DW-1];
            tx_sh  <= lsb_s ? (tx_sh >> 1) : (tx_sh << 1);
          end
          if (last_edge) begin
            rx   <= sample ? rx_nxt : rx_sh;
            done <= 1'b1;
          end
        end else begin
          half <= half - 16'd1;
        end
      end
    end
  end

  assign spi_sck  = ctrl[3] ? bb[2] : (busy ? sck_q : ctrl[1]);
  assign spi_mosi = ctrl[3] ? bb[1] : mosi_q;

  always_comb begin
    spi_ss = cs;
    if (ctrl[3]) spi_ss[0] = bb[3];
  end

endmodule
